// File: rtl/adex_pkg.sv
// Shared types and saturating helpers for the AdEx adaptation driver.
package adex_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_t;

  // Unsigned add clamped to max_val; the extra carry bit keeps overflow visible.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  // Unsigned subtract clamped at zero; the borrow bit selects the zero result.
  function automatic logic [31:0] sat_sub0(input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[32] ? 32'd0 : diff[31:0];
  endfunction

endpackage

// File: rtl/adex_w_tracker.sv
// Adaptation variable w: saturating jump per spike, geometric decay per tick.
module adex_w_tracker
  import adex_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int W_INC        = 16,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spike,
  output logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] w_next
);

  localparam int          CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [31:0] W_MAX = 32'((64'd1 << DATA_W) - 64'd1);

  logic [CNT_W-1:0]  decay_cnt;
  logic              tick;
  logic [DATA_W-1:0] step;

  // Next w: spike increment wins over a coincident decay tick.
  always_comb begin
    tick = (decay_cnt == CNT_W'(DECAY_PERIOD - 1));
    step = w >> DECAY_SHIFT;
    if (step == '0) begin
      step = DATA_W'(1);
    end
    w_next = w;
    if (spike) begin
      w_next = DATA_W'(sat_add(32'(w), 32'(W_INC), W_MAX));
    end else if (tick && (w != '0)) begin
      w_next = DATA_W'(sat_sub0(32'(w), 32'(step)));
    end
  end

  // Decay counter free-runs and wraps regardless of spikes; w follows w_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt <= '0;
      w         <= '0;
    end else begin
      decay_cnt <= tick ? '0 : decay_cnt + CNT_W'(1);
      w         <= w_next;
    end
  end

endmodule

// File: rtl/adex_adaptation_driver.sv
// Drives the neuron input current: stimulus minus adaptation, gated by refractory.
module adex_adaptation_driver
  import adex_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int W_INC         = 16,
  parameter int DECAY_SHIFT   = 3,
  parameter int DECAY_PERIOD  = 8,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] stim_in,
  input  logic              stim_valid,
  output logic              stim_ready,
  input  logic              spike_in,
  output logic [DATA_W-1:0] current_out,
  output logic [DATA_W-1:0] w_out,
  output logic              refractory
);

  if (REFRAC_CYCLES < 1 || REFRAC_CYCLES > 255) begin : g_bad_refrac
    $error("REFRAC_CYCLES must be in 1..255");
  end
  if (DECAY_PERIOD < 1 || DECAY_PERIOD > 256) begin : g_bad_period
    $error("DECAY_PERIOD must be in 1..256");
  end

  state_t            state, next_state;
  logic [7:0]        refrac_cnt, refrac_next;
  logic [DATA_W-1:0] stim_reg, stim_next;
  logic [DATA_W-1:0] w, w_next;
  logic [DATA_W-1:0] current_next;

  adex_w_tracker #(
    .DATA_W      (DATA_W),
    .W_INC       (W_INC),
    .DECAY_SHIFT (DECAY_SHIFT),
    .DECAY_PERIOD(DECAY_PERIOD)
  ) u_w_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (spike_in),
    .w     (w),
    .w_next(w_next)
  );

  assign stim_ready = (state == INTEGRATE);
  assign refractory = (state == REFRACTORY);
  assign w_out      = w;

  // Next-state, refractory countdown, stimulus capture and next current.
  always_comb begin
    next_state  = state;
    refrac_next = refrac_cnt;
    stim_next   = (stim_valid && stim_ready) ? stim_in : stim_reg;
    case (state)
      INTEGRATE: begin
        if (spike_in) begin
          next_state  = REFRACTORY;
          refrac_next = 8'(REFRAC_CYCLES - 1);
        end
      end
      REFRACTORY: begin
        if (refrac_cnt == 8'd0) begin
          next_state = INTEGRATE;
        end else begin
          refrac_next = refrac_cnt - 8'd1;
        end
      end
      default: next_state = INTEGRATE;
    endcase
    current_next = (next_state == REFRACTORY) ? '0
                 : DATA_W'(sat_sub0(32'(stim_next), 32'(w_next)));
  end

  // Control and output registers; outputs reflect next-state values one edge late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INTEGRATE;
      refrac_cnt  <= 8'd0;
      stim_reg    <= '0;
      current_out <= '0;
    end else begin
      state       <= next_state;
      refrac_cnt  <= refrac_next;
      stim_reg    <= stim_next;
      current_out <= current_next;
    end
  end

endmodule
